// File: rtl/alu_muldiv_unit.sv
// Handshaked EX-stage execute unit: single-cycle ALU ops, fixed-latency multiply,
// iterative radix-2 restoring divide, RV64 word mode, tag carried to writeback.

package alu_muldiv_pkg;
  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_AND    = 5'd2,
    ALU_OR     = 5'd3,
    ALU_XOR    = 5'd4,
    ALU_SLL    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_SLT    = 5'd8,
    ALU_SLTU   = 5'd9,
    ALU_MUL    = 5'd10,
    ALU_MULH   = 5'd11,
    ALU_MULHSU = 5'd12,
    ALU_MULHU  = 5'd13,
    ALU_DIV    = 5'd14,
    ALU_DIVU   = 5'd15,
    ALU_REM    = 5'd16,
    ALU_REMU   = 5'd17
  } alu_op_t;
endpackage

module alu_muldiv_unit
  import alu_muldiv_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned MUL_LATENCY = 3,
  parameter int unsigned TAG_W       = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  alu_op_t          alu_op,
  input  logic             alu_32,
  input  logic [XLEN-1:0]  operand1,
  input  logic [XLEN-1:0]  operand2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic             zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned PW    = 2 * XLEN;
  localparam int unsigned SH_W  = $clog2(XLEN);
  localparam int unsigned CNT_W = 7;
  localparam bit          WORD_OK = (XLEN == 64);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  function automatic logic [XLEN-1:0] word_sext(input logic [31:0] v);
    logic signed [31:0] s;
    s = v;
    return XLEN'(s);
  endfunction

  function automatic logic [XLEN-1:0] word_zext(input logic [31:0] v);
    return XLEN'(v);
  endfunction

  function automatic logic is_mul(input alu_op_t op);
    return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
  endfunction

  function automatic logic is_div(input alu_op_t op);
    return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

  function automatic logic is_rem(input alu_op_t op);
    return op inside {ALU_REM, ALU_REMU};
  endfunction

  function automatic logic a1_signed(input alu_op_t op);
    return !(op inside {ALU_SRL, ALU_SLTU, ALU_MULHU, ALU_DIVU, ALU_REMU});
  endfunction

  function automatic logic a2_signed(input alu_op_t op);
    return !(op inside {ALU_SLTU, ALU_MULHU, ALU_MULHSU, ALU_DIVU, ALU_REMU});
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  alu_op_t            op_q, op_d;
  logic               w32_q, w32_d;
  logic [XLEN-1:0]    a_q, a_d, b_q, b_d, rem_q, rem_d;
  logic               q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic               out_valid_d, zero_d;
  logic [XLEN-1:0]    result_d;
  logic [TAG_W-1:0]   out_tag_d;

  logic               accept, busy, w32_in, w32_cur, in_a1s, in_a2s;
  alu_op_t            op_cur;
  logic [XLEN-1:0]    a_in, b_in, a_cur, b_cur, mag_a, mag_b, min_val;
  logic               sign_a, sign_b, div_zero, div_ovf;
  logic [SH_W-1:0]    shamt;
  logic [XLEN-1:0]    fast_res, mul_res, res_raw;
  logic signed [XLEN:0] a_s, b_s;
  logic [PW-1:0]      prod;
  logic               top_bit, ge, finish;
  logic [XLEN:0]      rem_sh;
  logic [XLEN-1:0]    rem_nxt, q_nxt;

  assign accept = in_valid && in_ready;
  assign busy   = (state_q == ST_BUSY);
  assign w32_in = WORD_OK && alu_32;

  // Accept only from IDLE or from DONE while the result is being consumed.
  always_comb begin
    in_ready = 1'b0;
    if (!reset && !flush)
      in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  end

  // Operand conditioning at issue: word-mode extension, magnitudes, divide special cases.
  always_comb begin
    in_a1s = a1_signed(alu_op);
    in_a2s = a2_signed(alu_op);
    a_in   = operand1;
    b_in   = operand2;
    if (w32_in) begin
      a_in = in_a1s ? word_sext(operand1[31:0]) : word_zext(operand1[31:0]);
      b_in = in_a2s ? word_sext(operand2[31:0]) : word_zext(operand2[31:0]);
    end
    sign_a   = in_a1s && a_in[XLEN-1];
    sign_b   = in_a2s && b_in[XLEN-1];
    mag_a    = sign_a ? -a_in : a_in;
    mag_b    = sign_b ? -b_in : b_in;
    min_val  = '0;
    min_val[XLEN-1] = 1'b1;
    if (w32_in) min_val = word_sext(32'h8000_0000);
    div_zero = (b_in == '0);
    div_ovf  = in_a1s && (a_in == min_val) && (b_in == '1);
    shamt    = b_in[SH_W-1:0];
    if (w32_in) shamt[SH_W-1] = 1'b0;
  end

  // Multiplier: live operands at issue, latched operands while counting out the latency.
  always_comb begin
    op_cur  = busy ? op_q : alu_op;
    w32_cur = busy ? w32_q : w32_in;
    a_cur   = busy ? a_q : a_in;
    b_cur   = busy ? b_q : b_in;
    a_s     = {a1_signed(op_cur) && a_cur[XLEN-1], a_cur};
    b_s     = {a2_signed(op_cur) && b_cur[XLEN-1], b_cur};
    prod    = PW'(a_s) * PW'(b_s);
    mul_res = (op_cur == ALU_MUL) ? prod[XLEN-1:0] : prod[PW-1:XLEN];
  end

  // One restoring divide step on magnitudes; a_q shifts dividend out and quotient in.
  always_comb begin
    top_bit = w32_q ? a_q[31] : a_q[XLEN-1];
    rem_sh  = {rem_q, top_bit};
    ge      = (rem_sh >= {1'b0, b_q});
    rem_nxt = ge ? (rem_sh[XLEN-1:0] - b_q) : rem_sh[XLEN-1:0];
    q_nxt   = {a_q[XLEN-2:0], ge};
  end

  // Single-cycle results, including multiply when latency is 1 and divide special cases.
  always_comb begin
    fast_res = '0;
    case (alu_op)
      ALU_ADD:  fast_res = a_in + b_in;
      ALU_SUB:  fast_res = a_in - b_in;
      ALU_AND:  fast_res = a_in & b_in;
      ALU_OR:   fast_res = a_in | b_in;
      ALU_XOR:  fast_res = a_in ^ b_in;
      ALU_SLL:  fast_res = a_in << shamt;
      ALU_SRL:  fast_res = a_in >> shamt;
      ALU_SRA:  fast_res = $signed(a_in) >>> shamt;
      ALU_SLT:  fast_res = XLEN'($signed(a_in) < $signed(b_in));
      ALU_SLTU: fast_res = XLEN'(a_in < b_in);
      ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU: fast_res = mul_res;
      ALU_DIV, ALU_DIVU: fast_res = div_zero ? '1 : a_in;
      ALU_REM, ALU_REMU: fast_res = div_zero ? a_in : '0;
      default:  fast_res = '0;
    endcase
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    w32_d       = w32_q;
    a_d         = a_q;
    b_d         = b_q;
    rem_d       = rem_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    out_valid_d = out_valid;
    result_d    = result;
    zero_d      = zero;
    out_tag_d   = out_tag;
    res_raw     = '0;
    finish      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if ((state_q == ST_DONE) && out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
        if (accept) begin
          op_d      = alu_op;
          w32_d     = w32_in;
          out_tag_d = in_tag;
          a_d       = a_in;
          b_d       = b_in;
          if (is_mul(alu_op) && (MUL_LATENCY > 1)) begin
            state_d     = ST_BUSY;
            out_valid_d = 1'b0;
            cnt_d       = CNT_W'(MUL_LATENCY - 2);
          end else if (is_div(alu_op) && !div_zero && !div_ovf) begin
            state_d     = ST_BUSY;
            out_valid_d = 1'b0;
            a_d         = mag_a;
            b_d         = mag_b;
            rem_d       = '0;
            cnt_d       = w32_in ? CNT_W'(31) : CNT_W'(XLEN - 1);
            q_neg_d     = sign_a ^ sign_b;
            r_neg_d     = sign_a;
          end else begin
            res_raw = fast_res;
            finish  = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (is_div(op_q)) begin
          a_d   = q_nxt;
          rem_d = rem_nxt;
          if (cnt_q == '0) begin
            finish  = 1'b1;
            res_raw = is_rem(op_q) ? (r_neg_q ? -rem_nxt : rem_nxt)
                                   : (q_neg_q ? -q_nxt : q_nxt);
          end
        end else if (cnt_q == '0) begin
          finish  = 1'b1;
          res_raw = mul_res;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (finish) begin
      result_d    = w32_cur ? word_sext(res_raw[31:0]) : res_raw;
      zero_d      = (result_d == '0);
      state_d     = ST_DONE;
      out_valid_d = 1'b1;
    end
    if (flush) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= ALU_ADD;
      w32_q     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      out_tag   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      w32_q     <= w32_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rem_q     <= rem_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      out_valid <= out_valid_d;
      result    <= result_d;
      zero      <= zero_d;
      out_tag   <= out_tag_d;
    end
  end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Scoreboard bench for alu_muldiv_unit: expected results queued at issue, compared at handshake.

module tb_alu_muldiv_unit;
  import alu_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, alu_32;
  logic        out_valid, out_ready, zero;
  alu_op_t     alu_op;
  logic [63:0] operand1, operand2, result;
  logic [4:0]  in_tag, out_tag;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  tag;
    int          due;
  } exp_t;

  exp_t sb[$];
  bit   lat_done = 1'b0;

  alu_muldiv_unit #(.XLEN(64), .MUL_LATENCY(3), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .alu_32(alu_32),
    .operand1(operand1), .operand2(operand2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%h expected=0x%h", name, got, exp);
    end
  endtask

  // Output monitor: latency on first valid cycle, payload every valid cycle, pop on handshake.
  always @(negedge clk) begin
    #2;
    if (!reset && out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 64'(out_valid), 64'd0);
      end else begin
        if (!lat_done) begin
          check($sformatf("latency_t%0d", sb[0].tag), 64'(cyc), 64'(sb[0].due));
          lat_done = 1'b1;
        end
        check($sformatf("result_t%0d", sb[0].tag), result, sb[0].res);
        check($sformatf("zero_t%0d", sb[0].tag), 64'(zero), 64'(sb[0].res == 64'd0));
        check($sformatf("tag_t%0d", sb[0].tag), 64'(out_tag), 64'(sb[0].tag));
        if (!out_ready) begin
          check("hold_in_ready", 64'(in_ready), 64'd0);
        end else begin
          void'(sb.pop_front());
          lat_done = 1'b0;
        end
      end
    end
  end

  task automatic issue(input alu_op_t op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] tag,
                       input logic [63:0] exp, input int lat);
    int budget;
    exp_t e;
    budget = 0;
    @(negedge clk);
    alu_op = op; alu_32 = w; operand1 = a; operand2 = b; in_tag = tag; in_valid = 1'b1;
    #1;
    while (!in_ready && budget < 300) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (!in_ready) begin
      check("issue_timeout", 64'(in_ready), 64'd1);
    end else begin
      e.res = exp; e.tag = tag; e.due = cyc + lat;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
      lat_done = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] a, b, e;
    alu_op_t     op;
    bit          seen;
    int          n;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = ALU_ADD; alu_32 = 1'b0; operand1 = '0; operand2 = '0; in_tag = '0;
    repeat (3) @(negedge clk);
    #2 check("reset_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #2;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_result", result, 64'd0);
    check("reset_zero", 64'(zero), 64'd0);
    check("reset_out_tag", 64'(out_tag), 64'd0);
    check("idle_in_ready", 64'(in_ready), 64'd1);

    // Simple ops and word mode
    issue(ALU_ADD,  1'b0, 64'd5, 64'd7, 5'd3, 64'd12, 1);
    issue(ALU_ADD,  1'b1, 64'h7FFF_FFFF, 64'd1, 5'd4, 64'hFFFF_FFFF_8000_0000, 1);
    issue(ALU_SUB,  1'b0, 64'd9, 64'd9, 5'd5, 64'd0, 1);
    issue(ALU_SRA,  1'b1, 64'h8000_0000, 64'd4, 5'd6, 64'hFFFF_FFFF_F800_0000, 1);
    issue(ALU_SRL,  1'b1, 64'h8000_0000, 64'd4, 5'd7, 64'h0000_0000_0800_0000, 1);
    issue(ALU_SLL,  1'b1, 64'd1, 64'd33, 5'd8, 64'd2, 1);
    issue(ALU_SLL,  1'b0, 64'd1, 64'd33, 5'd9, 64'h0000_0002_0000_0000, 1);
    issue(ALU_SLT,  1'b0, '1, 64'd1, 5'd10, 64'd1, 1);
    issue(ALU_SLTU, 1'b0, '1, 64'd1, 5'd11, 64'd0, 1);
    issue(alu_op_t'(5'd31), 1'b0, 64'd5, 64'd7, 5'd12, 64'd0, 1);
    drain(20);

    // Multiply family
    issue(ALU_MULHU,  1'b0, '1, 64'd2, 5'd13, 64'd1, 3);
    issue(ALU_MULH,   1'b0, '1, '1, 5'd14, 64'd0, 3);
    issue(ALU_MULHSU, 1'b0, '1, 64'd2, 5'd15, '1, 3);
    issue(ALU_MUL,    1'b0, 64'h1_0000_0001, 64'd3, 5'd16, 64'h3_0000_0003, 3);
    drain(30);

    // Multiply held by back-pressure
    out_ready = 1'b0;
    issue(ALU_MUL, 1'b0, 64'd6, 64'd7, 5'd17, 64'd42, 3);
    n = 0;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    out_ready = 1'b1;
    drain(10);

    // Iterative divide
    issue(ALU_DIV,  1'b0, -64'sd7, 64'd2, 5'd18, -64'sd3, 65);
    issue(ALU_REM,  1'b0, -64'sd7, 64'd2, 5'd19, -64'sd1, 65);
    issue(ALU_DIVU, 1'b1, 64'd100, 64'd7, 5'd20, 64'd14, 33);
    drain(300);

    // Divide special cases
    issue(ALU_DIV,  1'b0, 64'd123, 64'd0, 5'd21, '1, 1);
    issue(ALU_REMU, 1'b0, 64'd42, 64'd0, 5'd22, 64'd42, 1);
    issue(ALU_DIV,  1'b0, 64'h8000_0000_0000_0000, '1, 5'd23, 64'h8000_0000_0000_0000, 1);
    issue(ALU_REM,  1'b1, 64'h8000_0000, '1, 5'd24, 64'd0, 1);
    issue(ALU_DIV,  1'b1, 64'h8000_0000, '1, 5'd25, 64'hFFFF_FFFF_8000_0000, 1);
    drain(20);

    // Random simple ops
    for (int i = 0; i < 8; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case (i % 5)
        0: begin op = ALU_ADD; e = a + b; end
        1: begin op = ALU_SUB; e = a - b; end
        2: begin op = ALU_XOR; e = a ^ b; end
        3: begin op = ALU_AND; e = a & b; end
        default: begin op = ALU_OR; e = a | b; end
      endcase
      issue(op, 1'b0, a, b, 5'(i), e, 1);
    end
    drain(20);

    // Random divides
    for (int i = 0; i < 6; i++) begin
      a = {$urandom, $urandom};
      b = 64'($urandom_range(2, 100000));
      if (i % 2 == 1) b = -b;
      case (i % 4)
        0: begin op = ALU_DIV;  e = 64'($signed(a) / $signed(b)); end
        1: begin op = ALU_DIVU; e = a / b; end
        2: begin op = ALU_REM;  e = 64'($signed(a) % $signed(b)); end
        default: begin op = ALU_REMU; e = a % b; end
      endcase
      issue(op, 1'b0, a, b, 5'(i + 8), e, 65);
    end
    drain(500);

    // Flush during a divide, with a new op offered in the flush cycle
    @(negedge clk);
    alu_op = ALU_DIV; alu_32 = 1'b0; operand1 = 64'd1000; operand2 = 64'd3; in_tag = 5'd1;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    alu_op = ALU_ADD; operand1 = 64'd1; operand2 = 64'd2; in_tag = 5'd2;
    in_valid = 1'b1; flush = 1'b1;
    #1 check("flush_blocks_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 begin in_valid = 1'b0; flush = 1'b0; end
    @(negedge clk);
    #2;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      #2 seen = seen | out_valid;
    end
    check("flush_never_valid", 64'(seen), 64'd0);
    issue(ALU_ADD, 1'b0, 64'd100, 64'd23, 5'd2, 64'd123, 1);
    drain(10);

    // Reset in the middle of a multiply
    @(negedge clk);
    alu_op = ALU_MUL; operand1 = 64'd3; operand2 = 64'd5; in_tag = 5'd9; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #2;
    check("rst_mul_out_valid", 64'(out_valid), 64'd0);
    check("rst_mul_result", result, 64'd0);
    check("rst_mul_zero", 64'(zero), 64'd0);
    check("rst_mul_out_tag", 64'(out_tag), 64'd0);
    check("rst_mul_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    #2 check("rst_mul_stays_idle", 64'(out_valid), 64'd0);
    issue(ALU_XOR, 1'b0, 64'hF0F0, 64'h0FF0, 5'd30, 64'hFF00, 1);
    drain(10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
